// File: rtl/cabac_value_refill.sv
// Holds m_range/m_value for the CABAC regular-bin decoder and refills value low bits from a byte-fed 16-bit reservoir.
// Latency: bin and byte accepts take effect on the accepting edge; state_valid rises 3 cycles after init_start at best.
// Backpressure: bin_ready drops while the reservoir holds fewer than k bits; byte_ready drops while it holds more than 8.
module cabac_value_refill (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_start,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        bin_valid,
   output logic        bin_ready,
   input  logic [15:0] value_in,
   input  logic [8:0]  range_in,
   input  logic [2:0]  numbits_in,
   input  logic        lps_in,
   input  logic        mps_renorm_n_in,
   output logic [8:0]  m_range,
   output logic [15:0] m_value,
   output logic        state_valid
);

   typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, RUN} state_t;

   state_t      state, state_nxt;
   logic [15:0] resv, resv_nxt;
   logic [4:0]  cnt, cnt_nxt;
   logic [8:0]  range_nxt;
   logic [15:0] value_nxt;

   logic        shift_en;
   logic [2:0]  k;
   logic        byte_acc, bin_acc;
   logic [15:0] refill_bits;
   logic [15:0] resv_post;
   logic [4:0]  cnt_post;
   logic [15:0] byte_ins;

   // Only renormalising bins consume bits; numbits_in is a don't-care otherwise.
   assign shift_en = lps_in | ~mps_renorm_n_in;
   assign k        = shift_en ? numbits_in : 3'd0;

   // Ready signals depend on state, fill level and the presented bin, never on the valids.
   always_comb begin
      byte_ready = 1'b0;
      bin_ready  = 1'b0;
      case (state)
         LOAD_HI, LOAD_LO: byte_ready = 1'b1;
         RUN: begin
            byte_ready = (cnt <= 5'd8);
            bin_ready  = ({2'b00, k} <= cnt);
         end
         default: ;
      endcase
   end

   // An init pulse swallows any handshake occurring in the same cycle.
   assign byte_acc = byte_valid & byte_ready & ~init_start;
   assign bin_acc  = bin_valid  & bin_ready  & ~init_start;

   // Top k reservoir bits right-aligned; k = 0 shifts everything out and yields zero.
   assign refill_bits = {9'd0, resv[15:9]} >> (3'd7 - k);

   // Consume first, then drop the new byte directly below the surviving bits. Bits below cnt
   // are always zero, so OR-ing the byte in is an exact insert.
   assign resv_post = bin_acc ? (resv << k) : resv;
   assign cnt_post  = bin_acc ? (cnt - {2'b00, k}) : cnt;
   assign byte_ins  = {byte_data, 8'd0} >> cnt_post;

   // Next-state for FSM, reservoir and architectural registers.
   always_comb begin
      state_nxt = state;
      resv_nxt  = resv;
      cnt_nxt   = cnt;
      range_nxt = m_range;
      value_nxt = m_value;
      if (init_start) begin
         state_nxt = LOAD_HI;
         resv_nxt  = 16'd0;
         cnt_nxt   = 5'd0;
      end else begin
         case (state)
            IDLE: ;
            LOAD_HI: begin
               if (byte_acc) begin
                  value_nxt[15:8] = byte_data;
                  state_nxt       = LOAD_LO;
               end
            end
            LOAD_LO: begin
               if (byte_acc) begin
                  value_nxt[7:0] = byte_data;
                  range_nxt      = 9'd510;
                  state_nxt      = RUN;
               end
            end
            RUN: begin
               if (bin_acc) begin
                  range_nxt = range_in;
                  value_nxt = value_in | refill_bits;
               end
               resv_nxt = resv_post;
               cnt_nxt  = cnt_post;
               if (byte_acc) begin
                  resv_nxt = resv_post | byte_ins;
                  cnt_nxt  = cnt_post + 5'd8;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register; reset discards everything including a half-finished load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         resv        <= 16'd0;
         cnt         <= 5'd0;
         m_range     <= 9'd0;
         m_value     <= 16'd0;
         state_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         resv        <= resv_nxt;
         cnt         <= cnt_nxt;
         m_range     <= range_nxt;
         m_value     <= value_nxt;
         state_valid <= (state_nxt == RUN);
      end
   end

endmodule
